cam_vsearch: RTL and testbench
==============================

# cam_vsearch

Parametrised content-addressable memory with per-entry valid bits, unique-key insert, delete-by-key and a registered search port with priority-encoded hit index. It replaces zero-as-empty CAM storage, so the value 0 is a legal key, and it is the lookup stage for tag and ID tracking logic that needs occupancy status and a single hit index rather than a raw match vector.

## Interface
- WIDTH, 8, key width in bits (>= 1)
- DEPTH, 16, number of entries (>= 2)
- IDX_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  insert request
- wr_data  input  WIDTH  key to insert
- del_en  input  1  delete request
- del_data  input  WIDTH  key to delete
- srch_en  input  1  search request
- srch_key  input  WIDTH  key to search
- wr_ack  output  1  insert stored (1-cycle pulse)
- wr_err  output  1  insert rejected (1-cycle pulse)
- wr_idx  output  IDX_W  slot written, or slot of existing duplicate
- del_hit  output  1  delete found and removed its key (1-cycle pulse)
- srch_valid  output  1  search result valid (1-cycle pulse)
- srch_hit  output  1  key present
- srch_idx  output  IDX_W  lowest matching index
- srch_match  output  DEPTH  per-entry match vector
- count  output  IDX_W+1  number of valid entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Storage: DEPTH x WIDTH key array plus DEPTH valid bits. An entry matches only if valid and key equal.
- Keys are unique. At most one valid entry ever matches a given key.
- Insert (wr_en=1, del_en=0):
  - Duplicate (key already valid): no write; wr_err=1, wr_idx=existing slot.
  - Else if full: no write; wr_err=1, wr_idx=0.
  - Else: write to lowest-index invalid slot, set its valid bit; wr_ack=1, wr_idx=that slot; count+1.
- Delete (del_en=1): clear the valid bit of the matching entry. The key array is left untouched. del_hit=1 and count-1 if a match existed; otherwise no state change and del_hit=0.
- Delete has priority: when wr_en and del_en are both 1, the delete executes and the insert is rejected (wr_err=1, wr_idx=0), whatever the data values.
- Search (srch_en=1):
  - Compares srch_key against the array contents as they were before the current edge.
  - srch_match = per-entry match bits.
  - srch_hit = OR of srch_match.
  - srch_idx = lowest set bit, or 0 on a miss.
- Insert, delete and search may all be asserted in the same cycle. The search never sees an insert or delete issued in that same cycle.
- Free-slot and duplicate detection use pre-edge contents. A slot freed by a delete cannot be refilled in the same cycle.
- count, full and empty are always consistent with the valid bits: full = (count == DEPTH), empty = (count == 0).

## Timing
- All outputs are registered. Latency is 1 cycle from the request edge to the result edge, for insert, delete and search.
- wr_ack, wr_err, del_hit and srch_valid are 0 in any cycle that follows a cycle with no corresponding request.
- srch_hit, srch_idx and srch_match hold their last value while srch_valid=0.
- wr_idx holds its last value when no insert is in progress.
- Back-to-back requests every cycle are supported at full throughput, with no stall or ready signal. A search issued the cycle after an insert edge sees the new entry.
- Reset, synchronous and taking precedence over all requests:
  - All valid bits cleared; count=0, empty=1, full=0.
  - wr_ack, wr_err, wr_idx, del_hit, srch_valid, srch_hit, srch_idx and srch_match all 0.
  - Key array contents are don't-care.
- A request issued in the same cycle as rst=1 is discarded and produces no response pulse afterwards.

## Test plan
- After reset, search key 0x00 -> srch_valid=1, srch_hit=0, srch_match=0, empty=1. Insert 0x00 -> wr_ack=1, wr_idx=0. Search 0x00 -> srch_hit=1, srch_idx=0.
- Insert 0x11, 0x22, 0x33 back-to-back -> wr_idx=0,1,2, count=3. Insert 0x22 again -> wr_err=1, wr_idx=1, count stays 3.
- Fill all 16 entries with 0x01..0x10 -> full=1. Insert 0x55 -> wr_err=1, wr_idx=0. Delete 0x05 -> del_hit=1, count=15. Insert 0x55 -> wr_idx=4, full=1.
- Same cycle: del_en with 0x02 (present), wr_en with 0x77, srch_en with 0x02 -> del_hit=1, wr_err=1, srch_hit=1 at old index. Next-cycle search 0x02 -> srch_hit=0.
- Delete absent key 0x99 -> del_hit=0, count unchanged. Delete on empty CAM -> del_hit=0, empty stays 1.
- Assert rst mid-stream with wr_en=1 -> next cycle count=0, empty=1, all pulses 0. A search for the previously stored key -> srch_hit=0.

Source files
------------

// File: rtl/cam_vsearch.sv
// Content-addressable memory with per-entry valid bits, unique-key insert,
// delete-by-key and a registered priority-encoded search port.
module cam_vsearch #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               del_en,
    input  logic [WIDTH-1:0]   del_data,
    input  logic               srch_en,
    input  logic [WIDTH-1:0]   srch_key,
    output logic               wr_ack,
    output logic               wr_err,
    output logic [IDX_W-1:0]   wr_idx,
    output logic               del_hit,
    output logic               srch_valid,
    output logic               srch_hit,
    output logic [IDX_W-1:0]   srch_idx,
    output logic [DEPTH-1:0]   srch_match,
    output logic [IDX_W:0]     count,
    output logic               full,
    output logic               empty
);

    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0] ONE_CNT   = (IDX_W + 1)'(1);

    logic [WIDTH-1:0] r_keys [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [DEPTH-1:0] w_wrMatch;
    logic [DEPTH-1:0] w_delMatch;
    logic [DEPTH-1:0] w_srchMatch;
    logic [DEPTH-1:0] w_freeVec;

    logic             w_wrDup;
    logic             w_delAny;
    logic             w_freeAny;
    logic             w_srchAny;
    logic             w_doInsert;
    logic             w_doDelete;

    logic [IDX_W-1:0] w_dupIdx;
    logic [IDX_W-1:0] w_delIdx;
    logic [IDX_W-1:0] w_freeIdx;
    logic [IDX_W-1:0] w_srchIdx;
    logic [IDX_W-1:0] w_wrIdxNext;
    logic [IDX_W:0]   w_countNext;

    // Lowest set bit wins; an all-zero vector encodes to index 0.
    function automatic logic [IDX_W-1:0] lowestSet(input logic [DEPTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        w_wrMatch   = '0;
        w_delMatch  = '0;
        w_srchMatch = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wrMatch[i]   = r_valid[i] && (r_keys[i] == wr_data);
            w_delMatch[i]  = r_valid[i] && (r_keys[i] == del_data);
            w_srchMatch[i] = r_valid[i] && (r_keys[i] == srch_key);
        end
    end

    assign w_freeVec = ~r_valid;
    assign w_wrDup   = |w_wrMatch;
    assign w_delAny  = |w_delMatch;
    assign w_freeAny = |w_freeVec;
    assign w_srchAny = |w_srchMatch;

    assign w_dupIdx  = lowestSet(w_wrMatch);
    assign w_delIdx  = lowestSet(w_delMatch);
    assign w_freeIdx = lowestSet(w_freeVec);
    assign w_srchIdx = lowestSet(w_srchMatch);

    // A simultaneous delete always wins, so insert and delete never both commit.
    assign w_doInsert = wr_en && !del_en && !w_wrDup && w_freeAny;
    assign w_doDelete = del_en && w_delAny;

    always_comb begin
        w_wrIdxNext = '0;
        if (!del_en) begin
            if (w_wrDup) begin
                w_wrIdxNext = w_dupIdx;
            end else if (w_freeAny) begin
                w_wrIdxNext = w_freeIdx;
            end
        end
    end

    always_comb begin
        w_countNext = count;
        if (w_doInsert) begin
            w_countNext = count + ONE_CNT;
        end else if (w_doDelete) begin
            w_countNext = count - ONE_CNT;
        end
    end

    // Key storage has no reset: an entry is meaningful only while its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && w_doInsert) begin
            r_keys[w_freeIdx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            wr_idx     <= '0;
            del_hit    <= 1'b0;
            srch_valid <= 1'b0;
            srch_hit   <= 1'b0;
            srch_idx   <= '0;
            srch_match <= '0;
        end else begin
            wr_ack     <= w_doInsert;
            wr_err     <= wr_en && !w_doInsert;
            del_hit    <= w_doDelete;
            srch_valid <= srch_en;

            if (wr_en) begin
                wr_idx <= w_wrIdxNext;
            end

            if (w_doDelete) begin
                r_valid[w_delIdx] <= 1'b0;
            end
            if (w_doInsert) begin
                r_valid[w_freeIdx] <= 1'b1;
            end

            count <= w_countNext;
            full  <= (w_countNext == DEPTH_CNT);
            empty <= (w_countNext == '0);

            // Search results hold between requests so consumers can sample late.
            if (srch_en) begin
                srch_match <= w_srchMatch;
                srch_hit   <= w_srchAny;
                srch_idx   <= w_srchIdx;
            end
        end
    end

endmodule

// File: tb/tb_cam_vsearch.sv
// Directed self-checking bench for cam_vsearch: a vector table for single-cycle
// behaviour plus hand-written sequences for fill, same-cycle and reset cases.
module tb_cam_vsearch;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        del_en;
    logic [7:0]  del_data;
    logic        srch_en;
    logic [7:0]  srch_key;
    logic        wr_ack;
    logic        wr_err;
    logic [3:0]  wr_idx;
    logic        del_hit;
    logic        srch_valid;
    logic        srch_hit;
    logic [3:0]  srch_idx;
    logic [15:0] srch_match;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    cam_vsearch #(.WIDTH(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .del_en     (del_en),
        .del_data   (del_data),
        .srch_en    (srch_en),
        .srch_key   (srch_key),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .wr_idx     (wr_idx),
        .del_hit    (del_hit),
        .srch_valid (srch_valid),
        .srch_hit   (srch_hit),
        .srch_idx   (srch_idx),
        .srch_match (srch_match),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wrEn;
        logic [7:0]  wrData;
        logic        delEn;
        logic [7:0]  delData;
        logic        srchEn;
        logic [7:0]  srchKey;
        logic        eAck;
        logic        eErr;
        logic [3:0]  eWrIdx;
        logic        eDel;
        logic        eSv;
        logic        eSh;
        logic [3:0]  eSIdx;
        logic [15:0] eMatch;
        logic [4:0]  eCount;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(
        input logic r, input logic we, input logic [7:0] wd,
        input logic de, input logic [7:0] dd,
        input logic se, input logic [7:0] sk,
        input logic eAck, input logic eErr, input logic [3:0] eWrIdx,
        input logic eDel, input logic eSv, input logic eSh,
        input logic [3:0] eSIdx, input logic [15:0] eMatch, input logic [4:0] eCount);
        vec_t v;
        v.rst = r;      v.wrEn = we;     v.wrData = wd;
        v.delEn = de;   v.delData = dd;
        v.srchEn = se;  v.srchKey = sk;
        v.eAck = eAck;  v.eErr = eErr;   v.eWrIdx = eWrIdx;
        v.eDel = eDel;  v.eSv = eSv;     v.eSh = eSh;
        v.eSIdx = eSIdx; v.eMatch = eMatch; v.eCount = eCount;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic we, input logic [7:0] wd,
                                 input logic de, input logic [7:0] dd,
                                 input logic se, input logic [7:0] sk);
        rst      = r;
        wr_en    = we;
        wr_data  = wd;
        del_en   = de;
        del_data = dd;
        srch_en  = se;
        srch_key = sk;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag,
                            input logic eAck, input logic eErr, input logic [3:0] eWrIdx,
                            input logic eDel, input logic eSv, input logic eSh,
                            input logic [3:0] eSIdx, input logic [15:0] eMatch,
                            input logic [4:0] eCount);
        checkOutput({tag, ".wr_ack"},     32'(wr_ack),     32'(eAck));
        checkOutput({tag, ".wr_err"},     32'(wr_err),     32'(eErr));
        checkOutput({tag, ".wr_idx"},     32'(wr_idx),     32'(eWrIdx));
        checkOutput({tag, ".del_hit"},    32'(del_hit),    32'(eDel));
        checkOutput({tag, ".srch_valid"}, 32'(srch_valid), 32'(eSv));
        checkOutput({tag, ".srch_hit"},   32'(srch_hit),   32'(eSh));
        checkOutput({tag, ".srch_idx"},   32'(srch_idx),   32'(eSIdx));
        checkOutput({tag, ".srch_match"}, 32'(srch_match), 32'(eMatch));
        checkOutput({tag, ".count"},      32'(count),      32'(eCount));
        checkOutput({tag, ".full"},       32'(full),       32'(eCount == 5'd16));
        checkOutput({tag, ".empty"},      32'(empty),      32'(eCount == 5'd0));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; del_en = 1'b0; del_data = '0;
        srch_en = 1'b0; srch_key = '0;

        //             rst we wd     de dd     se sk      ack err widx del sv sh sidx match    cnt
        tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00,  0, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h00,  0, 0, 4'd0, 0, 1, 0, 4'd0, 16'h0000, 5'd0);
        tbl[2]  = mk(0, 1, 8'h00, 0, 8'h00, 0, 8'h00,  1, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd1);
        tbl[3]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h00,  0, 0, 4'd0, 0, 1, 1, 4'd0, 16'h0001, 5'd1);
        tbl[4]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00,  0, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd0);
        tbl[5]  = mk(0, 1, 8'h11, 0, 8'h00, 0, 8'h00,  1, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd1);
        tbl[6]  = mk(0, 1, 8'h22, 0, 8'h00, 0, 8'h00,  1, 0, 4'd1, 0, 0, 0, 4'd0, 16'h0000, 5'd2);
        tbl[7]  = mk(0, 1, 8'h33, 0, 8'h00, 0, 8'h00,  1, 0, 4'd2, 0, 0, 0, 4'd0, 16'h0000, 5'd3);
        tbl[8]  = mk(0, 1, 8'h22, 0, 8'h00, 0, 8'h00,  0, 1, 4'd1, 0, 0, 0, 4'd0, 16'h0000, 5'd3);
        tbl[9]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h33,  0, 0, 4'd1, 0, 1, 1, 4'd2, 16'h0004, 5'd3);
        tbl[10] = mk(0, 0, 8'h00, 1, 8'h99, 0, 8'h00,  0, 0, 4'd1, 0, 0, 1, 4'd2, 16'h0004, 5'd3);
        tbl[11] = mk(0, 0, 8'h00, 1, 8'h22, 0, 8'h00,  0, 0, 4'd1, 1, 0, 1, 4'd2, 16'h0004, 5'd2);
        tbl[12] = mk(0, 1, 8'h22, 0, 8'h00, 1, 8'h22,  1, 0, 4'd1, 0, 1, 0, 4'd0, 16'h0000, 5'd3);
        tbl[13] = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h22,  0, 0, 4'd1, 0, 1, 1, 4'd1, 16'h0002, 5'd3);
        tbl[14] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00,  0, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd0);
        tbl[15] = mk(0, 0, 8'h00, 1, 8'h00, 0, 8'h00,  0, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd0);

        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].wrEn, tbl[i].wrData, tbl[i].delEn,
                          tbl[i].delData, tbl[i].srchEn, tbl[i].srchKey);
            checkAll($sformatf("vec%0d", i), tbl[i].eAck, tbl[i].eErr, tbl[i].eWrIdx,
                     tbl[i].eDel, tbl[i].eSv, tbl[i].eSh, tbl[i].eSIdx,
                     tbl[i].eMatch, tbl[i].eCount);
        end

        // Fill every slot with keys 0x01..0x10, then exercise the full boundary.
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        checkAll("fillRst", 0, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 8'(i + 1), 0, 8'h00, 0, 8'h00);
            checkAll($sformatf("fill%0d", i), 1, 0, 4'(i), 0, 0, 0, 4'd0, 16'h0000, 5'(i + 1));
        end
        applyStimulus(0, 1, 8'h55, 0, 8'h00, 0, 8'h00);
        checkAll("insFull", 0, 1, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd16);
        applyStimulus(0, 0, 8'h00, 1, 8'h05, 0, 8'h00);
        checkAll("del05", 0, 0, 4'd0, 1, 0, 0, 4'd0, 16'h0000, 5'd15);
        applyStimulus(0, 1, 8'h55, 0, 8'h00, 0, 8'h00);
        checkAll("ins55", 1, 0, 4'd4, 0, 0, 0, 4'd0, 16'h0000, 5'd16);

        // Delete, insert and search together: delete wins, search sees old contents.
        applyStimulus(0, 1, 8'h77, 1, 8'h02, 1, 8'h02);
        checkAll("sameCyc", 0, 1, 4'd0, 1, 1, 1, 4'd1, 16'h0002, 5'd15);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 8'h02);
        checkAll("srchAfterDel", 0, 0, 4'd0, 0, 1, 0, 4'd0, 16'h0000, 5'd15);

        // Reset mid-stream discards the concurrent insert entirely.
        applyStimulus(0, 1, 8'h66, 0, 8'h00, 0, 8'h00);
        checkAll("ins66", 1, 0, 4'd1, 0, 0, 0, 4'd0, 16'h0000, 5'd16);
        applyStimulus(1, 1, 8'h44, 0, 8'h00, 1, 8'h10);
        checkAll("rstMid", 0, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        checkAll("postRst", 0, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 5'd0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 8'h10);
        checkAll("srchOld", 0, 0, 4'd0, 0, 1, 0, 4'd0, 16'h0000, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
